ami_axi_arbiter: RTL and testbench
==================================

# ami_axi_arbiter

Shares one single-beat AXI4 master port (`axi_m`) between `NUM_REQ` legacy AMI requesters. It sits between multi-port legacy apps such as DNNDrive and the virtual-memory AXI interface. Read and write channels are arbitrated independently, round-robin. Each issued AR/AW carries the requester index as its ID, and R beats are routed back by `rid`. Per-requester read credits bound the number of outstanding reads.

## Interface
Parameters:
- `NUM_REQ`, 2: number of AMI requesters (2..8).
- `MAX_OUT`, 8: maximum outstanding reads per requester (1..64).

Ports:
- `clk`  in  1: the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: AMI request valid, one bit per requester.
- `req_is_write`  in  NUM_REQ: 1 = write, 0 = read.
- `req_addr`  in  NUM_REQ×64: byte address. Bits [5:0] are always 0.
- `req_data`  in  NUM_REQ×512: write data.
- `req_grant`  out  NUM_REQ: one-cycle pulse. The request is consumed this cycle.
- `resp_valid`  out  NUM_REQ: read data valid.
- `resp_data`  out  512: read data, shared by all requesters.
- `resp_grant`  in  NUM_REQ: requester accepts the read data.
- `wr_pending`  out  NUM_REQ×7: outstanding write count per requester. Tied to 0 without the macro.
- `axi_m`  axi_bus_t.master: `arlen`/`awlen` = 0, `arsize`/`awsize` = 3'b110, `wstrb` = all ones, `wlast` = 1.

## Operation
- **Read slot.** One register holds `ar_valid`, `ar_addr` and `ar_id`.
  - The slot is free when `!ar_valid` or `arvalid && arready`.
  - When the slot is free, the read arbiter picks the first eligible requester at or after `rd_ptr`.
  - Eligible means `req_valid && !req_is_write && rd_cnt[i] != MAX_OUT`.
  - The winner gets `req_grant[i]`. Its address and index are loaded into the slot. `rd_ptr` moves to `i+1` modulo `NUM_REQ`.
- **Write slot.** It holds `aw_pend`, `w_pend`, the address, the data and the ID.
  - `awvalid = aw_pend` and `wvalid = w_pend`. Each flag clears on its own handshake.
  - The slot is free when both flags are clear, or both are being cleared this cycle.
  - Write arbitration is the same round-robin scheme, with its own `wr_ptr`.
- The read and write arbiters are independent. One requester can receive at most one grant per cycle. If it is the winner of both arbiters, the read wins. The write arbiter then excludes that requester and picks the next eligible one.
- **R routing.**
  - `resp_valid[i] = rvalid && rid == i`.
  - `rready = resp_grant[rid]`.
  - `resp_data = rdata`.
  - `rresp` is ignored.
- **Credits.** `rd_cnt[i]` increments on a read grant and decrements on an R handshake with `rid == i`. If both happen in the same cycle, the count is unchanged. The counter never wraps.
- **B channel.** `bready = 1`.

## Timing
- Combinational path from `req_valid` to `req_grant`, same cycle. `arvalid`/`awvalid`/`wvalid` assert on the next edge.
- Back-to-back throughput is 1 read + 1 write per cycle when `arready`/`awready`/`wready` are held high.
- AR, AW and W payloads are stable while their valid is high and unaccepted.
- AW and W may be accepted in different cycles. No new write is granted until both have been accepted.
- Reset values:
  - `ar_valid`, `aw_pend`, `w_pend` = 0.
  - `rd_ptr`, `wr_ptr` = 0.
  - `rd_cnt`, `wr_pending` = 0.
  - `req_grant` = 0.
- `arid`/`awid` = index, zero-extended. `rid` values at or above `NUM_REQ` are a protocol error. Such a beat is accepted (`rready = 1`) and dropped.
- Asserting reset mid-transaction discards in-flight state. The AXI slave must be reset at the same time.

## Configuration
- **`AMI_ARB_WR_TRACK_EN` defined:**
  - `wr_pending[i]` increments on write grant and decrements on a B handshake with `bid == i`. A simultaneous increment and decrement leaves it unchanged.
  - A requester with `wr_pending == 64` is not eligible for writes.
  - `bready = 1` still applies.
- **Undefined:** writes are fire-and-forget, `wr_pending` = 0, and no write backpressure is applied.

## Test plan
- Reads with `req_valid` = 2'b11, both reads, and AXI always ready -> grants alternate 01, 10, 01. The `arid` sequence is 0, 1, 0.
- Requester 0 issues 9 reads with `MAX_OUT` = 8 and no R beats -> 8 grants, then `req_grant[0]` stays 0. One R beat with `rid` = 0 -> the 9th is granted the next cycle.
- Write with `awready` = 1 and `wready` held 0 for 3 cycles -> `awvalid` drops after 1 cycle, `wvalid` is held with stable data, and no second write grant until W is accepted.
- R beats arrive out of order, `rid` = 1 then 0 -> `resp_valid` = 10 then 01. With `resp_grant[1]` = 0, `rready` = 0 and `rvalid` stalls.
- Requester 0 has both a read and a write pending while requester 1 writes -> the read goes to 0 and the write to 1 in the same cycle.
- `rst_n` pulled low while `arvalid` = 1 and `rd_cnt` = 3 -> all outputs return to reset values immediately (asynchronous). With the macro enabled, `wr_pending` returns to 0.

Source files
------------

// File: rtl/ami_axi_arbiter_if.sv
// Purpose: single-beat AXI4 bus bundle (64-bit address, 512-bit data, 4-bit ID).
// Latency: none, this is only wiring.
// Backpressure: standard AXI valid/ready on every channel.
interface axi_bus_t;
  // AR channel
  logic         arvalid;
  logic         arready;
  logic [63:0]  araddr;
  logic [3:0]   arid;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  // AW channel
  logic         awvalid;
  logic         awready;
  logic [63:0]  awaddr;
  logic [3:0]   awid;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  // W channel
  logic         wvalid;
  logic         wready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  // B channel
  logic         bvalid;
  logic         bready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  // R channel
  logic         rvalid;
  logic         rready;
  logic [3:0]   rid;
  logic [511:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );
endinterface

// File: rtl/ami_axi_arbiter.sv
// Purpose: round-robin share of one single-beat AXI4 master among NUM_REQ AMI requesters.
// Latency: req_grant is combinational; AR/AW/W valid rises on the next edge; R is routed back combinationally by rid.
// Backpressure: grant only into a free AR/write slot; read credits (MAX_OUT) per requester; AMI_ARB_WR_TRACK_EN adds write tracking.
module ami_axi_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int MAX_OUT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_is_write,
  input  logic [NUM_REQ-1:0][63:0]  req_addr,
  input  logic [NUM_REQ-1:0][511:0] req_data,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [511:0]              resp_data,
  input  logic [NUM_REQ-1:0]        resp_grant,
  output logic [NUM_REQ-1:0][6:0]   wr_pending,
  axi_bus_t.master                  axi_m
);

  localparam int          IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          AXI_ID_W = 4;
  localparam logic [6:0]  RD_LIMIT = 7'(MAX_OUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  // Round-robin pick: first set bit of elig at or after ptr. Returns {found, index}.
  // Scanning from the farthest candidate back to ptr lets the nearest one win.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                              input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] cand;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (elig[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  // Read slot
  logic                    ar_valid;
  logic [63:0]             ar_addr;
  logic [IDX_W-1:0]        ar_id;
  logic [IDX_W-1:0]        rd_ptr;
  logic [NUM_REQ-1:0][6:0] rd_cnt;

  // Write slot
  logic                    aw_pend;
  logic                    w_pend;
  logic [63:0]             aw_addr;
  logic [511:0]            w_data;
  logic [IDX_W-1:0]        aw_id;
  logic [IDX_W-1:0]        wr_ptr;

  // Arbitration
  logic                    ar_free;
  logic                    wr_free;
  logic                    aw_hs;
  logic                    w_hs;
  logic [NUM_REQ-1:0]      rd_elig;
  logic [NUM_REQ-1:0]      wr_elig;
  logic [NUM_REQ-1:0]      wr_ok;
  logic [IDX_W:0]          rd_pick;
  logic [IDX_W:0]          wr_pick;
  logic                    rd_found;
  logic                    wr_found;
  logic [IDX_W-1:0]        rd_win;
  logic [IDX_W-1:0]        wr_win;
  logic [NUM_REQ-1:0]      rd_gnt;
  logic [NUM_REQ-1:0]      wr_gnt;

  // R routing
  logic                    rid_ok;
  logic [IDX_W-1:0]        rid_idx;
  logic                    r_hs;

  assign aw_hs   = aw_pend && axi_m.awready;
  assign w_hs    = w_pend && axi_m.wready;
  // The AR slot can take a new request when empty or when it is draining this cycle.
  assign ar_free = !ar_valid || axi_m.arready;
  // The write slot is reusable once each half is either idle or accepted this cycle.
  assign wr_free = (!aw_pend || aw_hs) && (!w_pend || w_hs);

  assign rid_ok  = int'(axi_m.rid) < NUM_REQ;
  assign rid_idx = axi_m.rid[IDX_W-1:0];
  // Out-of-range IDs are drained so a misbehaving slave cannot stall the R channel.
  assign axi_m.rready = rid_ok ? resp_grant[rid_idx] : 1'b1;
  assign r_hs    = axi_m.rvalid && axi_m.rready;

  // Eligibility and round-robin selection for both channels; a read winner is removed from the write race.
  always_comb begin
    rd_gnt = '0;
    wr_gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_elig[i] = req_valid[i] && !req_is_write[i] && (rd_cnt[i] != RD_LIMIT) && ar_free;
    end
    rd_pick  = rr_pick(rd_elig, rd_ptr);
    rd_found = rd_pick[IDX_W];
    rd_win   = rd_pick[IDX_W-1:0];
    if (rd_found) rd_gnt[rd_win] = 1'b1;

    for (int i = 0; i < NUM_REQ; i++) begin
      wr_elig[i] = req_valid[i] && req_is_write[i] && !rd_gnt[i] && wr_ok[i] && wr_free;
    end
    wr_pick  = rr_pick(wr_elig, wr_ptr);
    wr_found = wr_pick[IDX_W];
    wr_win   = wr_pick[IDX_W-1:0];
    if (wr_found) wr_gnt[wr_win] = 1'b1;
  end

  // Grants are forced low while reset is asserted so the AMI side never sees a consume.
  assign req_grant = rst_n ? (rd_gnt | wr_gnt) : '0;

  // Route each R beat to the requester named by rid.
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = axi_m.rvalid && (int'(axi_m.rid) == i);
    end
  end
  assign resp_data = axi_m.rdata;

  // AR slot and read pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_valid <= 1'b0;
      ar_addr  <= '0;
      ar_id    <= '0;
      rd_ptr   <= '0;
    end else if (ar_free) begin
      ar_valid <= rd_found;
      if (rd_found) begin
        ar_addr <= req_addr[rd_win];
        ar_id   <= rd_win;
        rd_ptr  <= (rd_win == LAST_IDX) ? '0 : rd_win + 1'b1;
      end
    end
  end

  // Write slot: AW and W drain independently; a new grant reloads both halves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      aw_id   <= '0;
      wr_ptr  <= '0;
    end else begin
      if (aw_hs) aw_pend <= 1'b0;
      if (w_hs)  w_pend  <= 1'b0;
      if (wr_found) begin
        aw_pend <= 1'b1;
        w_pend  <= 1'b1;
        aw_addr <= req_addr[wr_win];
        w_data  <= req_data[wr_win];
        aw_id   <= wr_win;
        wr_ptr  <= (wr_win == LAST_IDX) ? '0 : wr_win + 1'b1;
      end
    end
  end

  // Read credits: +1 on grant, -1 on a routed R handshake, saturating at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rd_gnt[i] && !(r_hs && rid_ok && rid_idx == IDX_W'(i))) begin
          rd_cnt[i] <= rd_cnt[i] + 7'd1;
        end else if (!rd_gnt[i] && r_hs && rid_ok && rid_idx == IDX_W'(i) && rd_cnt[i] != 7'd0) begin
          rd_cnt[i] <= rd_cnt[i] - 7'd1;
        end
      end
    end
  end

`ifdef AMI_ARB_WR_TRACK_EN
  logic [NUM_REQ-1:0][6:0] wr_cnt;
  logic                    b_hs;
  logic                    unused_b;

  assign b_hs     = axi_m.bvalid && axi_m.bready;
  assign unused_b = ^{axi_m.bresp, 1'b0};

  // Outstanding-write counters: +1 on write grant, -1 on B with matching bid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (wr_gnt[i] && !(b_hs && int'(axi_m.bid) == i)) begin
          wr_cnt[i] <= wr_cnt[i] + 7'd1;
        end else if (!wr_gnt[i] && b_hs && int'(axi_m.bid) == i && wr_cnt[i] != 7'd0) begin
          wr_cnt[i] <= wr_cnt[i] - 7'd1;
        end
      end
    end
  end

  // A requester with 64 writes in flight is held off the write arbiter.
  always_comb begin
    wr_ok = '0;
    for (int i = 0; i < NUM_REQ; i++) wr_ok[i] = (wr_cnt[i] != 7'd64);
  end
  assign wr_pending = wr_cnt;
`else
  logic unused_b;

  // Fire-and-forget writes: B responses are drained and never counted.
  assign unused_b   = ^{axi_m.bvalid, axi_m.bid, axi_m.bresp};
  assign wr_ok      = '1;
  assign wr_pending = '0;
`endif

  logic unused_r;
  assign unused_r = ^{axi_m.rresp, axi_m.rlast};

  // AXI master drive: single-beat 64-byte bursts, IDs are the zero-extended requester index.
  assign axi_m.arvalid = ar_valid;
  assign axi_m.araddr  = ar_addr;
  assign axi_m.arid    = AXI_ID_W'(ar_id);
  assign axi_m.arlen   = 8'd0;
  assign axi_m.arsize  = 3'b110;
  assign axi_m.arburst = 2'b01;
  assign axi_m.awvalid = aw_pend;
  assign axi_m.awaddr  = aw_addr;
  assign axi_m.awid    = AXI_ID_W'(aw_id);
  assign axi_m.awlen   = 8'd0;
  assign axi_m.awsize  = 3'b110;
  assign axi_m.awburst = 2'b01;
  assign axi_m.wvalid  = w_pend;
  assign axi_m.wdata   = w_data;
  assign axi_m.wstrb   = '1;
  assign axi_m.wlast   = 1'b1;
  assign axi_m.bready  = 1'b1;

endmodule

// File: tb/tb_ami_axi_arbiter.sv
// Purpose: directed, table-driven check of ami_axi_arbiter with NUM_REQ=2, MAX_OUT=8.
// Latency: grants sampled on the falling edge, registered AXI outputs 1 ns after the rising edge.
// Backpressure: the AXI slave side is driven directly by the bench.
module tb_ami_axi_arbiter;

  logic                clk;
  logic                rst_n;
  logic [1:0]          req_valid;
  logic [1:0]          req_is_write;
  logic [1:0][63:0]    req_addr;
  logic [1:0][511:0]   req_data;
  logic [1:0]          req_grant;
  logic [1:0]          resp_valid;
  logic [511:0]        resp_data;
  logic [1:0]          resp_grant;
  logic [1:0][6:0]     wr_pending;

  axi_bus_t axi ();

  ami_axi_arbiter #(.NUM_REQ(2), .MAX_OUT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_is_write (req_is_write),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_grant    (req_grant),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_grant   (resp_grant),
    .wr_pending   (wr_pending),
    .axi_m        (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0]  A0 = 64'h0000_0000_1000_0040;
  localparam logic [63:0]  A1 = 64'h0000_0000_2000_0080;
  localparam logic [511:0] D0 = {16{32'hA5A5_0000}};
  localparam logic [511:0] D1 = {16{32'h5A5A_1111}};
  localparam logic [511:0] R0 = {16{32'hC0DE_0000}};
  localparam logic [511:0] R1 = {16{32'hC0DE_0001}};

  typedef struct {
    logic [1:0] vld;
    logic [1:0] wr;
    logic [1:0] gnt;
    logic       arv;
    logic [3:0] arid;
    logic       awv;
    logic [3:0] awid;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  exp_a;
    logic [511:0] exp_d;
    int           gcount;
    logic         last_g;
    logic         seen;

    // read/read alternation, then read+write in one cycle, then write round-robin
    tbl[0] = '{vld: 2'b11, wr: 2'b00, gnt: 2'b01, arv: 1'b1, arid: 4'd0, awv: 1'b0, awid: 4'd0};
    tbl[1] = '{vld: 2'b11, wr: 2'b00, gnt: 2'b10, arv: 1'b1, arid: 4'd1, awv: 1'b0, awid: 4'd0};
    tbl[2] = '{vld: 2'b11, wr: 2'b00, gnt: 2'b01, arv: 1'b1, arid: 4'd0, awv: 1'b0, awid: 4'd0};
    tbl[3] = '{vld: 2'b11, wr: 2'b10, gnt: 2'b11, arv: 1'b1, arid: 4'd0, awv: 1'b1, awid: 4'd1};
    tbl[4] = '{vld: 2'b11, wr: 2'b11, gnt: 2'b01, arv: 1'b0, arid: 4'd0, awv: 1'b1, awid: 4'd0};
    tbl[5] = '{vld: 2'b11, wr: 2'b11, gnt: 2'b10, arv: 1'b0, arid: 4'd0, awv: 1'b1, awid: 4'd1};
    tbl[6] = '{vld: 2'b00, wr: 2'b00, gnt: 2'b00, arv: 1'b0, arid: 4'd0, awv: 1'b0, awid: 4'd0};

    rst_n        = 1'b0;
    req_valid    = 2'b11;
    req_is_write = 2'b00;
    req_addr[0]  = A0;
    req_addr[1]  = A1;
    req_data[0]  = D0;
    req_data[1]  = D1;
    resp_grant   = 2'b11;
    axi.arready  = 1'b1;
    axi.awready  = 1'b1;
    axi.wready   = 1'b1;
    axi.bvalid   = 1'b0;
    axi.bid      = 4'd0;
    axi.bresp    = 2'b00;
    axi.rvalid   = 1'b0;
    axi.rid      = 4'd0;
    axi.rdata    = '0;
    axi.rresp    = 2'b00;
    axi.rlast    = 1'b1;

    // reset state
    #2;
    check("rst_grant",   req_grant, 2'b00);
    check("rst_arvalid", axi.arvalid, 1'b0);
    check("rst_awvalid", axi.awvalid, 1'b0);
    check("rst_wvalid",  axi.wvalid, 1'b0);
    check("rst_wr_pend", wr_pending, 14'd0);
    check("arlen",       axi.arlen, 8'd0);
    check("arsize",      axi.arsize, 3'b110);
    check("awsize",      axi.awsize, 3'b110);
    check("wstrb",       axi.wstrb, {64{1'b1}});
    check("wlast",       axi.wlast, 1'b1);
    check("bready",      axi.bready, 1'b1);
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // table-driven arbitration
    for (int i = 0; i < 7; i++) begin
      req_valid    = tbl[i].vld;
      req_is_write = tbl[i].wr;
      @(negedge clk);
      check($sformatf("v%0d_grant", i), req_grant, tbl[i].gnt);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_arvalid", i), axi.arvalid, tbl[i].arv);
      check($sformatf("v%0d_awvalid", i), axi.awvalid, tbl[i].awv);
      check($sformatf("v%0d_wvalid", i),  axi.wvalid,  tbl[i].awv);
      if (tbl[i].arv) begin
        exp_a = (tbl[i].arid == 4'd0) ? A0 : A1;
        check($sformatf("v%0d_arid", i),   axi.arid, tbl[i].arid);
        check($sformatf("v%0d_araddr", i), axi.araddr, exp_a);
      end
      if (tbl[i].awv) begin
        exp_a = (tbl[i].awid == 4'd0) ? A0 : A1;
        exp_d = (tbl[i].awid == 4'd0) ? D0 : D1;
        check($sformatf("v%0d_awid", i),   axi.awid, tbl[i].awid);
        check($sformatf("v%0d_awaddr", i), axi.awaddr, exp_a);
        check($sformatf("v%0d_wdata", i),  axi.wdata, exp_d);
      end
    end

    // W stalled for 3 cycles while AW is accepted at once
    axi.awready  = 1'b1;
    axi.wready   = 1'b0;
    req_valid    = 2'b10;
    req_is_write = 2'b10;
    @(negedge clk);
    check("wst_grant0", req_grant, 2'b10);
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("wst%0d_awvalid", c), axi.awvalid, (c == 0));
      check($sformatf("wst%0d_wvalid", c),  axi.wvalid, 1'b1);
      check($sformatf("wst%0d_wdata", c),   axi.wdata, D1);
      check($sformatf("wst%0d_nogrant", c), req_grant, 2'b00);
      @(posedge clk);
      #1;
    end
    axi.wready = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    if (req_grant == 2'b10) seen = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    if (req_grant == 2'b10) seen = 1'b1;
    check("wst_regrant", seen, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    req_is_write = 2'b00;
    @(posedge clk);
    #1;

    // R beats out of order, then a stalled beat and an out-of-range ID
    axi.rvalid = 1'b1;
    axi.rid    = 4'd1;
    axi.rdata  = R1;
    resp_grant = 2'b11;
    @(negedge clk);
    check("r1_resp_valid", resp_valid, 2'b10);
    check("r1_rready",     axi.rready, 1'b1);
    check("r1_resp_data",  resp_data, R1);
    @(posedge clk);
    #1;
    axi.rid   = 4'd0;
    axi.rdata = R0;
    @(negedge clk);
    check("r0_resp_valid", resp_valid, 2'b01);
    check("r0_rready",     axi.rready, 1'b1);
    check("r0_resp_data",  resp_data, R0);
    @(posedge clk);
    #1;
    axi.rid    = 4'd1;
    resp_grant = 2'b01;
    @(negedge clk);
    check("rstall_resp_valid", resp_valid, 2'b10);
    check("rstall_rready",     axi.rready, 1'b0);
    @(posedge clk);
    #1;
    axi.rid = 4'd5;
    @(negedge clk);
    check("rbad_resp_valid", resp_valid, 2'b00);
    check("rbad_rready",     axi.rready, 1'b1);
    @(posedge clk);
    #1;
    axi.rvalid = 1'b0;
    resp_grant = 2'b11;

    // read credits: 8 grants then blocked until one R beat returns
    do_reset();
    req_valid    = 2'b01;
    req_is_write = 2'b00;
    gcount = 0;
    last_g = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      last_g = req_grant[0];
      if (req_grant[0]) gcount++;
      @(posedge clk);
      #1;
    end
    check("cred_grants",  gcount, 8);
    check("cred_blocked", last_g, 1'b0);
    axi.rvalid = 1'b1;
    axi.rid    = 4'd0;
    axi.rdata  = R0;
    @(negedge clk);
    check("cred_resp_valid", resp_valid, 2'b01);
    check("cred_rready",     axi.rready, 1'b1);
    check("cred_same_cycle", req_grant, 2'b00);
    @(posedge clk);
    #1;
    axi.rvalid = 1'b0;
    @(negedge clk);
    check("cred_9th_grant", req_grant, 2'b01);
    @(posedge clk);
    #1;
    req_valid = 2'b00;

    // asynchronous reset while arvalid is high and three reads are outstanding
    do_reset();
    req_valid = 2'b01;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    req_valid   = 2'b00;
    axi.arready = 1'b0;
    #2;
    check("mid_arvalid_pre", axi.arvalid, 1'b1);
    req_valid = 2'b11;
    rst_n     = 1'b0;
    #1;
    check("mid_arvalid", axi.arvalid, 1'b0);
    check("mid_awvalid", axi.awvalid, 1'b0);
    check("mid_wvalid",  axi.wvalid, 1'b0);
    check("mid_grant",   req_grant, 2'b00);
    check("mid_wr_pend", wr_pending, 14'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    axi.arready = 1'b1;
    @(negedge clk);
    check("mid_ptr_reset", req_grant, 2'b01);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
